hdmi_frame_monitor: RTL and testbench
=====================================

# hdmi_frame_monitor

- Consumes the `vsync`/`hsync`/`vde` timing stream produced by the HDMI sync generator.
- Measures each frame's geometry: active pixels per line, active lines per frame, and hsync pulse width.
- Flags deviations from the configured resolution and reports per-frame results with a one-cycle `frame_done` strobe.
- Sits directly downstream of the sync generator, in front of pixel consumers and scoreboards.

## Interface

- `XResolution`, default 640: expected `vde` high cycles per active line.
- `YResolution`, default 480: expected active lines per frame.
- `HsyncWidth`, default 10: expected `hsync` high cycles per horizontal blank.
- `CntWidth`, default 16: width of all internal counters and count outputs.

- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `vsync_i`  in  1  vertical sync.
- `hsync_i`  in  1  horizontal sync.
- `vde_i`  in  1  video data enable.
- `frame_done_o`  out  1  one-cycle pulse at end of each checked frame.
- `line_len_err_o`  out  1  last frame had a line with `vde` run ≠ XResolution.
- `line_cnt_err_o`  out  1  last frame's active-line count ≠ YResolution.
- `hsync_len_err_o`  out  1  last frame had an hsync-only pulse ≠ HsyncWidth.
- `overlap_err_o`  out  1  last frame had `vde_i` high together with `hsync_i` or `vsync_i`.
- `lines_o`  out  CntWidth  active lines counted in last frame.
- `frames_o`  out  CntWidth  checked frames since reset; wraps modulo 2^CntWidth.
- `err_frames_o`  out  CntWidth  frames with any error; saturates at all-ones.

## Operation

- All three inputs are registered once (`*_q`); all decisions use the registered samples.
- FSM states:
  - Seek: entered after reset. Ignores input until a `vsync_q` falling edge (previous sample 1, current 0), then goes to Blank. The partial first frame is never checked.
  - Blank: evaluates levels in priority order `vsync_q` > `hsync_q` > `vde_q`. Enters Vsync, Hsync (hs_cnt=1) or Active (pix_cnt=1). Stays in Blank if all are low.
  - Active: increments pix_cnt while `vde_q`=1. On `vde_q`=0:
    - compare pix_cnt with XResolution; mismatch sets the pending line_len error;
    - increment line_cnt;
    - evaluate the Blank rules in the same cycle.
  - Hsync: increments hs_cnt while `hsync_q`=1.
    - `vsync_q`=1 goes to Vsync with no width check.
    - `hsync_q`=0 compares hs_cnt with HsyncWidth, then applies the Blank rules in the same cycle.
  - Vsync: waits for `vsync_q`=0, then ends the frame and returns to Blank.
    - `hsync_q` is don't-care in this state.
- Overlap: in any state except Seek, a sample with `vde_q`=1 and (`hsync_q`|`vsync_q`)=1 sets the pending overlap error. The Active length rules still apply.
- End of frame:
  - compare line_cnt with YResolution;
  - copy pending flags and line_cnt to the outputs;
  - pulse `frame_done_o`;
  - increment `frames_o`, and `err_frames_o` if any flag is set;
  - clear pending flags and line_cnt.
- Output flags and `lines_o` hold until the next `frame_done_o`.
- pix_cnt, hs_cnt and line_cnt saturate at 2^CntWidth−1.

## Timing

- Every output resets to 0. FSM resets to Seek and all counters to 0.
- Reset mid-frame discards the frame. No `frame_done_o` is issued for it.
- Latency: `frame_done_o` and the updated result outputs go high on the 2nd rising edge after the first edge that samples `vsync_i` low. All outputs change on that same edge.
- If the frame-end cycle also has `vde_q`=1, the overlap flag is included in the current frame's results.
- No backpressure and no handshake. A consumer must sample results during the `frame_done_o` cycle or before the next frame ends.

## Structure

- Package `hdmi_mon_pkg` holds the state enum `mon_state_t` {Seek, Blank, Active, Hsync, Vsync}.
- Sub-module `sat_counter` (parameterised width; clear, increment, saturate) is instantiated for pix_cnt, hs_cnt, line_cnt and `err_frames_o`.

## Test plan

All scenarios use XResolution=8, YResolution=4, HsyncWidth=3, each line = 8 vde + 1 gap + 3 hsync + 1 gap.

- Reset, then a partial frame and 2 clean frames → `frame_done_o` pulses exactly twice, all error flags 0, `lines_o`=4, `frames_o`=2, `err_frames_o`=0.
- One line with 7 vde cycles → `line_len_err_o`=1 at that `frame_done_o`, `err_frames_o`=1. Next clean frame clears the flag and `err_frames_o` stays 1.
- Frame with 5 active lines → `line_cnt_err_o`=1, `lines_o`=5.
- One hsync pulse of 4 cycles → `hsync_len_err_o`=1, other flags 0.
- `vde_i` and `hsync_i` high in the same cycle → `overlap_err_o`=1.
- `rst_i` pulsed mid-line → outputs 0 during reset, no `frame_done_o` for the interrupted frame. After the next vsync fall, the following clean frame reports `frames_o`=1 with no errors.

Source files
------------

// File: rtl/hdmi_mon_pkg.sv
// Shared types for the HDMI frame monitor.
package hdmi_mon_pkg;

    typedef enum logic [2:0] {
        Seek,
        Blank,
        Active,
        Hsync,
        Vsync
    } mon_state_t;

endpackage

// File: rtl/hdmi_frame_monitor_sat_counter.sv
// Saturating up-counter; clear and increment together restart the count at one.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    localparam logic [Width-1:0] MaxVal = '1;

    logic [Width-1:0] base_c;
    logic [Width-1:0] cnt_d;

    always_comb begin
        base_c = clr_i ? '0 : cnt_o;
        cnt_d  = base_c;
        if (inc_i && (base_c != MaxVal)) begin
            cnt_d = base_c + Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else begin
            cnt_o <= cnt_d;
        end
    end

endmodule

// File: rtl/hdmi_frame_monitor.sv
// Measures HDMI frame geometry from the sync stream and reports per-frame
// deviations from the configured resolution with a one-cycle frame_done strobe.
module hdmi_frame_monitor
    import hdmi_mon_pkg::*;
#(
    parameter int unsigned XResolution = 640,
    parameter int unsigned YResolution = 480,
    parameter int unsigned HsyncWidth  = 10,
    parameter int unsigned CntWidth    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                vsync_i,
    input  logic                hsync_i,
    input  logic                vde_i,
    output logic                frame_done_o,
    output logic                line_len_err_o,
    output logic                line_cnt_err_o,
    output logic                hsync_len_err_o,
    output logic                overlap_err_o,
    output logic [CntWidth-1:0] lines_o,
    output logic [CntWidth-1:0] frames_o,
    output logic [CntWidth-1:0] err_frames_o
);

    localparam logic [CntWidth-1:0] XRes   = CntWidth'(XResolution);
    localparam logic [CntWidth-1:0] YRes   = CntWidth'(YResolution);
    localparam logic [CntWidth-1:0] HsWdth = CntWidth'(HsyncWidth);

    mon_state_t state_q, state_d;

    logic vsync_q, hsync_q, vde_q, vsync_qq;
    logic [CntWidth-1:0] pix_cnt, hs_cnt, line_cnt;

    logic pix_clr, pix_inc, hs_clr, hs_inc, line_clr, line_inc;
    logic set_len, set_hs, set_ovl, frame_end_c, apply_blank;

    logic pend_len, pend_hs, pend_ovl;
    logic res_len, res_cnt, res_hs, res_ovl, eof_q;
    logic [CntWidth-1:0] res_lines;

    // Input sampling; vsync_qq is the previous vsync sample for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vsync_q  <= 1'b0;
            hsync_q  <= 1'b0;
            vde_q    <= 1'b0;
            vsync_qq <= 1'b0;
        end else begin
            vsync_q  <= vsync_i;
            hsync_q  <= hsync_i;
            vde_q    <= vde_i;
            vsync_qq <= vsync_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= Seek;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and counter controls; line ends fall through to the Blank rules.
    always_comb begin
        state_d     = state_q;
        pix_clr     = 1'b0;
        pix_inc     = 1'b0;
        hs_clr      = 1'b0;
        hs_inc      = 1'b0;
        line_inc    = 1'b0;
        set_len     = 1'b0;
        set_hs      = 1'b0;
        frame_end_c = 1'b0;
        apply_blank = 1'b0;
        set_ovl     = (state_q != Seek) && vde_q && (hsync_q || vsync_q);

        case (state_q)
            Seek: begin
                if (vsync_qq && !vsync_q) begin
                    state_d = Blank;
                end
            end
            Blank: apply_blank = 1'b1;
            Active: begin
                if (vde_q) begin
                    pix_inc = 1'b1;
                end else begin
                    set_len     = (pix_cnt != XRes);
                    line_inc    = 1'b1;
                    apply_blank = 1'b1;
                end
            end
            Hsync: begin
                if (vsync_q) begin
                    state_d = Vsync;
                end else if (hsync_q) begin
                    hs_inc = 1'b1;
                end else begin
                    set_hs      = (hs_cnt != HsWdth);
                    apply_blank = 1'b1;
                end
            end
            Vsync: begin
                if (!vsync_q) begin
                    frame_end_c = 1'b1;
                    state_d     = Blank;
                end
            end
            default: state_d = Seek;
        endcase

        if (apply_blank) begin
            if (vsync_q) begin
                state_d = Vsync;
            end else if (hsync_q) begin
                state_d = Hsync;
                hs_clr  = 1'b1;
                hs_inc  = 1'b1;
            end else if (vde_q) begin
                state_d = Active;
                pix_clr = 1'b1;
                pix_inc = 1'b1;
            end else begin
                state_d = Blank;
            end
        end

        line_clr = frame_end_c;
    end

    sat_counter #(.Width(CntWidth)) u_pix_cnt (
        .clk_i (clk_i), .rst_i (rst_i), .clr_i (pix_clr), .inc_i (pix_inc), .cnt_o (pix_cnt)
    );

    sat_counter #(.Width(CntWidth)) u_hs_cnt (
        .clk_i (clk_i), .rst_i (rst_i), .clr_i (hs_clr), .inc_i (hs_inc), .cnt_o (hs_cnt)
    );

    sat_counter #(.Width(CntWidth)) u_line_cnt (
        .clk_i (clk_i), .rst_i (rst_i), .clr_i (line_clr), .inc_i (line_inc), .cnt_o (line_cnt)
    );

    // Frame end snapshots results (including this cycle's flags); they publish one edge later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_len  <= 1'b0;
            pend_hs   <= 1'b0;
            pend_ovl  <= 1'b0;
            res_len   <= 1'b0;
            res_cnt   <= 1'b0;
            res_hs    <= 1'b0;
            res_ovl   <= 1'b0;
            res_lines <= '0;
            eof_q     <= 1'b0;
        end else begin
            eof_q <= frame_end_c;
            if (frame_end_c) begin
                res_len   <= pend_len | set_len;
                res_hs    <= pend_hs | set_hs;
                res_ovl   <= pend_ovl | set_ovl;
                res_cnt   <= (line_cnt != YRes);
                res_lines <= line_cnt;
                pend_len  <= 1'b0;
                pend_hs   <= 1'b0;
                pend_ovl  <= 1'b0;
            end else begin
                pend_len <= pend_len | set_len;
                pend_hs  <= pend_hs | set_hs;
                pend_ovl <= pend_ovl | set_ovl;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_done_o    <= 1'b0;
            line_len_err_o  <= 1'b0;
            line_cnt_err_o  <= 1'b0;
            hsync_len_err_o <= 1'b0;
            overlap_err_o   <= 1'b0;
            lines_o         <= '0;
            frames_o        <= '0;
        end else begin
            frame_done_o <= eof_q;
            if (eof_q) begin
                line_len_err_o  <= res_len;
                line_cnt_err_o  <= res_cnt;
                hsync_len_err_o <= res_hs;
                overlap_err_o   <= res_ovl;
                lines_o         <= res_lines;
                frames_o        <= frames_o + CntWidth'(1);
            end
        end
    end

    sat_counter #(.Width(CntWidth)) u_err_frames (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .inc_i (eof_q && (res_len || res_cnt || res_hs || res_ovl)),
        .cnt_o (err_frames_o)
    );

endmodule

// File: tb/tb_hdmi_frame_monitor.sv
// Directed bench for hdmi_frame_monitor with a small 8x4 geometry.
module tb_hdmi_frame_monitor;

    localparam int unsigned CntWidth = 16;

    logic clk_i = 1'b0;
    logic rst_i;
    logic vsync_i, hsync_i, vde_i;
    logic frame_done_o, line_len_err_o, line_cnt_err_o, hsync_len_err_o, overlap_err_o;
    logic [CntWidth-1:0] lines_o, frames_o, err_frames_o;

    int passed   = 0;
    int fails    = 0;
    int done_cnt = 0;
    int lat;

    hdmi_frame_monitor #(
        .XResolution (8),
        .YResolution (4),
        .HsyncWidth  (3),
        .CntWidth    (CntWidth)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .vsync_i         (vsync_i),
        .hsync_i         (hsync_i),
        .vde_i           (vde_i),
        .frame_done_o    (frame_done_o),
        .line_len_err_o  (line_len_err_o),
        .line_cnt_err_o  (line_cnt_err_o),
        .hsync_len_err_o (hsync_len_err_o),
        .overlap_err_o   (overlap_err_o),
        .lines_o         (lines_o),
        .frames_o        (frames_o),
        .err_frames_o    (err_frames_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (frame_done_o === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vs, input logic hs, input logic de, input int n);
        for (int i = 0; i < n; i++) begin
            vsync_i = vs;
            hsync_i = hs;
            vde_i   = de;
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic line(input int nvde, input int nhs);
        drive(1'b0, 1'b0, 1'b1, nvde);
        drive(1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 1'b0, nhs);
        drive(1'b0, 1'b0, 1'b0, 1);
    endtask

    task automatic clean_lines(input int n);
        for (int i = 0; i < n; i++) line(8, 3);
    endtask

    // Vsync pulse then idle until frame_done, recording the negedge index it appears on.
    task automatic vsync_wait(output int l);
        drive(1'b1, 1'b0, 1'b0, 2);
        vsync_i = 1'b0;
        hsync_i = 1'b0;
        vde_i   = 1'b0;
        l = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (frame_done_o === 1'b1) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic len, input logic cnt,
                               input logic hs, input logic ovl, input int lines,
                               input int frames, input int errf);
        vsync_wait(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        chk({tag, "_len_err"}, 32'(line_len_err_o), 32'(len));
        chk({tag, "_cnt_err"}, 32'(line_cnt_err_o), 32'(cnt));
        chk({tag, "_hs_err"}, 32'(hsync_len_err_o), 32'(hs));
        chk({tag, "_ovl_err"}, 32'(overlap_err_o), 32'(ovl));
        chk({tag, "_lines"}, 32'(lines_o), 32'(lines));
        chk({tag, "_frames"}, 32'(frames_o), 32'(frames));
        chk({tag, "_err_frames"}, 32'(err_frames_o), 32'(errf));
        @(negedge clk_i);
        chk({tag, "_done_pulse"}, 32'(frame_done_o), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_done"}, 32'(frame_done_o), 32'd0);
        chk({tag, "_flags"}, 32'({line_len_err_o, line_cnt_err_o, hsync_len_err_o, overlap_err_o}), 32'd0);
        chk({tag, "_lines"}, 32'(lines_o), 32'd0);
        chk({tag, "_frames"}, 32'(frames_o), 32'd0);
        chk({tag, "_err_frames"}, 32'(err_frames_o), 32'd0);
    endtask

    initial begin
        rst_i   = 1'b1;
        vsync_i = 1'b0;
        hsync_i = 1'b0;
        vde_i   = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Partial first frame: ignored until the first vsync fall.
        clean_lines(2);
        drive(1'b1, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b0, 6);
        chk("seek_no_done", 32'(done_cnt), 32'd0);

        clean_lines(4);
        check_frame("clean1", 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, 0);
        clean_lines(4);
        check_frame("clean2", 1'b0, 1'b0, 1'b0, 1'b0, 4, 2, 0);
        chk("done_count_2", 32'(done_cnt), 32'd2);

        line(7, 3);
        clean_lines(3);
        check_frame("short_line", 1'b1, 1'b0, 1'b0, 1'b0, 4, 3, 1);
        clean_lines(4);
        check_frame("clean3", 1'b0, 1'b0, 1'b0, 1'b0, 4, 4, 1);

        clean_lines(5);
        check_frame("five_lines", 1'b0, 1'b1, 1'b0, 1'b0, 5, 5, 2);

        clean_lines(1);
        line(8, 4);
        clean_lines(2);
        check_frame("long_hsync", 1'b0, 1'b0, 1'b1, 1'b0, 4, 6, 3);

        // Last vde cycle overlaps the first hsync cycle; hsync-only run stays 3.
        clean_lines(1);
        drive(1'b0, 1'b0, 1'b1, 7);
        drive(1'b0, 1'b1, 1'b1, 1);
        drive(1'b0, 1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 1'b0, 1);
        clean_lines(2);
        check_frame("overlap", 1'b0, 1'b0, 1'b0, 1'b1, 4, 7, 4);

        // Reset in the middle of an active line.
        clean_lines(2);
        drive(1'b0, 1'b0, 1'b1, 4);
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 2);
        @(negedge clk_i);
        check_reset_outputs("midreset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 1'b0, 1);
        clean_lines(1);
        drive(1'b1, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b0, 6);
        chk("reset_no_done", 32'(done_cnt), 32'd7);

        clean_lines(4);
        check_frame("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, 0);
        chk("done_count_final", 32'(done_cnt), 32'd8);

        $display("%0d/%0d checks passed", passed, passed + fails);
        $finish;
    end

endmodule
